// File: rtl/seq_stream_gen_if.sv
// seq_stream_gen_if: operator inputs and serial-bit outputs
// of the stimulus generator, grouped for the port list.
interface seq_stream_gen_if #(
    parameter int WIDTH = 8
);
    localparam int IW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sw;
    logic             btn_load;
    logic             rpt;
    logic             x;
    logic             x_vld;
    logic             busy;
    logic [IW-1:0]    bit_idx;

    modport master (
        output sw, btn_load, rpt,
        input  x, x_vld, busy, bit_idx
    );

    modport slave (
        input  sw, btn_load, rpt,
        output x, x_vld, busy, bit_idx
    );
endinterface

// File: rtl/seq_stream_gen.sv
// seq_stream_gen: serial stimulus source for the sequence detector.
// A debounced load latches sw; bits replay MSB-first on prescaled ticks.
module seq_stream_gen #(
    parameter int WIDTH     = 8,
    parameter int TICK_DIV  = 50000000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            reset,
    seq_stream_gen_if.slave bus
);
    localparam int IW  = $clog2(WIDTH + 1);
    localparam int PW  = $clog2(TICK_DIV);
    localparam int DBW = $clog2(DB_CYCLES + 1);

    localparam logic [IW-1:0]  LAST_IDX = IW'(WIDTH);
    localparam logic [PW-1:0]  PRE_TOP  = PW'(TICK_DIV - 1);
    localparam logic [DBW-1:0] DB_TOP   = DBW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_db_level;
    logic [DBW-1:0]   r_db_cnt;
    logic             r_load_pulse;
    logic [PW-1:0]    r_pre;
    state_t           r_state;
    logic             r_x;
    logic             r_x_vld;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_pat;
    logic [IW-1:0]    r_bit_idx;

    logic             w_tick;
    logic [IW-1:0]    w_idx_inc;
    state_t           w_state_nxt;
    logic             w_x_nxt;
    logic             w_x_vld_nxt;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [WIDTH-1:0] w_pat_nxt;
    logic [IW-1:0]    w_idx_nxt;

    assign w_tick    = (r_pre == PRE_TOP);
    // After a completed pass the index wraps to 1 on the first repeated bit.
    assign w_idx_inc = (r_bit_idx == LAST_IDX) ? IW'(1)
                                               : r_bit_idx + IW'(1);

    // Synchronize the raw button and debounce it; pulse on debounced rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_db_level   <= 1'b0;
            r_db_cnt     <= '0;
            r_load_pulse <= 1'b0;
        end else begin
            r_sync1      <= bus.btn_load;
            r_sync2      <= r_sync1;
            r_load_pulse <= 1'b0;
            if (r_sync2 != r_db_level) begin
                if (r_db_cnt == DB_TOP) begin
                    r_db_level   <= r_sync2;
                    r_db_cnt     <= '0;
                    r_load_pulse <= r_sync2;
                end else begin
                    r_db_cnt <= r_db_cnt + DBW'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    // Bit-period prescaler, realigned to zero by every load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
        end else if (r_load_pulse || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    // FSM and datapath register stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_x       <= 1'b0;
            r_x_vld   <= 1'b0;
            r_shreg   <= '0;
            r_pat     <= '0;
            r_bit_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_x       <= w_x_nxt;
            r_x_vld   <= w_x_vld_nxt;
            r_shreg   <= w_shreg_nxt;
            r_pat     <= w_pat_nxt;
            r_bit_idx <= w_idx_nxt;
        end
    end

    // Next-state logic; a load overrides any same-cycle tick.
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_x_vld_nxt = 1'b0;
        w_shreg_nxt = r_shreg;
        w_pat_nxt   = r_pat;
        w_idx_nxt   = r_bit_idx;
        if (r_load_pulse) begin
            w_pat_nxt   = bus.sw;
            w_shreg_nxt = bus.sw;
            w_idx_nxt   = '0;
            w_state_nxt = SHIFT;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_x_nxt = 1'b0;
                end
                SHIFT: begin
                    if (w_tick) begin
                        w_x_nxt     = r_shreg[WIDTH-1];
                        w_x_vld_nxt = 1'b1;
                        w_idx_nxt   = w_idx_inc;
                        w_shreg_nxt = r_shreg << 1;
                        if (w_idx_inc == LAST_IDX) begin
                            if (bus.rpt) begin
                                w_shreg_nxt = r_pat;
                            end else begin
                                w_state_nxt = DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    if (w_tick) begin
                        w_x_nxt     = 1'b0;
                        w_idx_nxt   = '0;
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign bus.x       = r_x;
    assign bus.x_vld   = r_x_vld;
    assign bus.busy    = (r_state != IDLE);
    assign bus.bit_idx = r_bit_idx;
endmodule

// File: tb/tb_seq_stream_gen.sv
// tb_seq_stream_gen: directed bench for seq_stream_gen with a
// time-based reference model compared on every cycle.
module tb_seq_stream_gen;
    localparam int W  = 6;
    localparam int TD = 4;
    localparam int DB = 3;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   ncmp = 0;
    int   nfail = 0;

    seq_stream_gen_if #(.WIDTH(W)) bus ();

    seq_stream_gen #(
        .WIDTH(W),
        .TICK_DIV(TD),
        .DB_CYCLES(DB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: button filter plus elapsed-time bit schedule.
    int         ms1 = 0, ms2 = 0, mlvl = 0, mrun = 0, mlp = 0;
    int         mmode = 0;
    int         mt = 0, mn = 0, mbi = 0;
    bit         mx = 1'b0, mxv = 1'b0;
    logic [W-1:0] mpat = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ms1 = 0; ms2 = 0; mlvl = 0; mrun = 0; mlp = 0;
            mmode = 0; mt = 0; mn = 0; mbi = 0;
            mx = 1'b0; mxv = 1'b0; mpat = '0;
        end else begin
            mxv = 1'b0;
            if (mlp != 0) begin
                mpat  = bus.sw;
                mt    = 0;
                mn    = 0;
                mbi   = 0;
                mmode = 1;
            end else if (mmode == 1) begin
                mt++;
                if (mt % TD == 0) begin
                    mx  = mpat[W-1-(mn % W)];
                    mn++;
                    mxv = 1'b1;
                    mbi = ((mn - 1) % W) + 1;
                    if (mn % W == 0 && !bus.rpt) mmode = 2;
                end
            end else if (mmode == 2) begin
                mt++;
                if (mt % TD == 0) begin
                    mx    = 1'b0;
                    mbi   = 0;
                    mmode = 0;
                end
            end
            mlp = 0;
            if (ms2 != mlvl) begin
                mrun++;
                if (mrun == DB) begin
                    mlvl = ms2;
                    mrun = 0;
                    mlp  = mlvl;
                end
            end else begin
                mrun = 0;
            end
            ms2 = ms1;
            ms1 = int'(bus.btn_load);
        end
    end

    bit s_bit[$];
    int s_idx[$];
    int s_cyc[$];
    int lp_cyc[$];

    // Per-cycle compare against the model, plus strobe/load logging.
    always @(negedge clk) begin
        if (bus.x_vld) begin
            s_bit.push_back(bus.x);
            s_idx.push_back(int'(bus.bit_idx));
            s_cyc.push_back(cyc);
        end
        if (dut.r_load_pulse) lp_cyc.push_back(cyc);
        ncmp++;
        if (bus.x !== mx || bus.x_vld !== mxv ||
            bus.busy !== (mmode != 0) || int'(bus.bit_idx) != mbi) begin
            nfail++;
            $display("FAIL model cyc=%0d x=%0b/%0b vld=%0b/%0b busy=%0b/%0b idx=%0d/%0d (got/req)",
                     cyc, bus.x, mx, bus.x_vld, mxv, bus.busy, (mmode != 0),
                     bus.bit_idx, mbi);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clr();
        s_bit.delete();
        s_idx.delete();
        s_cyc.delete();
        lp_cyc.delete();
    endtask

    task automatic wait_strobes(input int n, input int budget, input string nm);
        int c = 0;
        while (s_bit.size() < n && c < budget) begin
            step(1);
            c++;
        end
        chk(nm, int'(s_bit.size() >= n), 1);
    endtask

    task automatic wait_idle(input int budget, input string nm, output int at);
        int c = 0;
        while (bus.busy && c < budget) begin
            step(1);
            c++;
        end
        at = cyc;
        chk(nm, int'(bus.busy), 0);
    endtask

    task automatic press();
        bus.btn_load = 1'b1;
        step(8);
        bus.btn_load = 1'b0;
        step(8);
    endtask

    function automatic int unsigned bits_val(input int from, input int n);
        int unsigned v = 0;
        for (int i = 0; i < n; i++) v = (v << 1) | int'(s_bit[from+i]);
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int idle_at;
        int pre;
        int bad;
        int hits;
        int hit_pos;
        int bounce_end;
        logic [5:0] sh;

        reset        = 1'b1;
        bus.sw       = '0;
        bus.btn_load = 1'b0;
        bus.rpt      = 1'b0;
        step(3);
        chk("reset_state", int'({bus.x, bus.x_vld, bus.busy, bus.bit_idx}), 0);
        reset = 1'b0;
        step(3);

        // Test 1: clean press of 110010, single pass.
        clr();
        bus.sw = 6'b110010;
        press();
        wait_strobes(6, 60, "t1_strobes");
        wait_idle(20, "t1_idle", idle_at);
        chk("t1_nstrobe", s_bit.size(), 6);
        chk("t1_bits", int'(bits_val(0, 6)), 6'b110010);
        chk("t1_nload", lp_cyc.size(), 1);
        chk("t1_first_lat", s_cyc[0] - lp_cyc[0], 5);
        bad = 0;
        for (int i = 1; i < 6; i++) if (s_cyc[i] - s_cyc[i-1] != 4) bad++;
        chk("t1_spacing", bad, 0);
        chk("t1_busy_drop", idle_at - s_cyc[5], 4);
        chk("t1_x_idle", int'(bus.x), 0);
        sh = '0;
        hits = 0;
        hit_pos = -1;
        for (int i = 0; i < s_bit.size(); i++) begin
            sh = {sh[4:0], s_bit[i]};
            if (i >= 5 && (sh == 6'b110010 || sh == 6'b110110)) begin
                hits++;
                hit_pos = i;
            end
        end
        chk("t6_det_hits", hits, 1);
        chk("t6_det_pos", hit_pos, 5);
        step(4);

        // Test 2: bouncing button, then a steady hold.
        clr();
        bus.sw = 6'b100111;
        for (int k = 0; k < 5; k++) begin
            bus.btn_load = (k % 2 == 0);
            step(2);
        end
        bounce_end = cyc;
        bus.btn_load = 1'b1;
        step(10);
        bus.btn_load = 1'b0;
        wait_strobes(6, 60, "t2_strobes");
        wait_idle(20, "t2_idle", idle_at);
        chk("t2_nload", lp_cyc.size(), 1);
        chk("t2_no_early", int'(s_cyc[0] > bounce_end), 1);
        chk("t2_nstrobe", s_bit.size(), 6);
        chk("t2_bits", int'(bits_val(0, 6)), 6'b100111);
        step(4);

        // Test 3: repeat mode, rpt cleared during the third pass.
        clr();
        bus.sw  = 6'b110110;
        bus.rpt = 1'b1;
        press();
        wait_strobes(14, 120, "t3_strobes");
        bus.rpt = 1'b0;
        wait_idle(60, "t3_idle", idle_at);
        chk("t3_nstrobe", s_bit.size(), 18);
        chk("t3_bits", int'(bits_val(0, 18)), 18'b110110110110110110);
        bad = 0;
        for (int i = 0; i < 18; i++) if (s_idx[i] != (i % 6) + 1) bad++;
        chk("t3_idx_seq", bad, 0);
        chk("t3_idx6", s_idx[6], 1);
        chk("t3_idx11", s_idx[11], 6);
        step(4);

        // Test 4: sw edit mid-pass is ignored; re-press restarts.
        clr();
        bus.sw       = 6'b110010;
        bus.btn_load = 1'b1;
        wait_strobes(1, 30, "t4_s1");
        bus.sw       = 6'b011011;
        bus.btn_load = 1'b0;
        wait_strobes(2, 20, "t4_s2");
        step(2);
        bus.btn_load = 1'b1;
        begin
            int c = 0;
            while (lp_cyc.size() < 2 && c < 30) begin
                step(1);
                c++;
            end
        end
        chk("t4_nload", lp_cyc.size(), 2);
        bus.btn_load = 1'b0;
        pre = 0;
        for (int i = 0; i < s_cyc.size(); i++) if (s_cyc[i] <= lp_cyc[1]) pre++;
        chk("t4_midpass", int'(pre >= 2 && pre < 6), 1);
        chk("t4_prefix", int'(bits_val(0, pre)), int'(6'b110010 >> (6 - pre)));
        wait_strobes(pre + 6, 60, "t4_strobes");
        wait_idle(20, "t4_idle", idle_at);
        chk("t4_total", s_bit.size(), pre + 6);
        chk("t4_new_bits", int'(bits_val(pre, 6)), 6'b011011);
        chk("t4_restart_lat", s_cyc[pre] - lp_cyc[1], 5);
        chk("t4_restart_idx", s_idx[pre], 1);
        chk("t4_last_idx", s_idx[pre+5], 6);
        step(4);

        // Test 5: asynchronous reset in the middle of bit 3.
        clr();
        bus.sw       = 6'b101111;
        bus.btn_load = 1'b1;
        wait_strobes(3, 40, "t5_s3");
        bus.btn_load = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_pre_busy", int'(bus.busy), 1);
        chk("t5_pre_idx", int'(bus.bit_idx), 3);
        chk("t5_pre_x", int'(bus.x), 1);
        reset = 1'b1;
        #1;
        chk("t5_async_clear", int'({bus.x, bus.x_vld, bus.busy, bus.bit_idx}), 0);
        step(2);
        reset = 1'b0;
        clr();
        step(40);
        chk("t5_no_strobes", s_bit.size(), 0);
        chk("t5_no_load", lp_cyc.size(), 0);
        chk("t5_idle", int'(bus.busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
